// File: rtl/inst_encoder_pkg.sv
// Shared encoder/decoder definitions: micro-op codes, RV32I opcode/funct
// constants, the canonical NOP, FSM states and field-packing helpers.
package inst_encoder_pkg;

    // Micro-op codes presented on in_op; codes 10..15 are undefined.
    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpAnd  = 4'd2,
        OpOr   = 4'd3,
        OpAddi = 4'd4,
        OpLui  = 4'd5,
        OpJal  = 4'd6,
        OpJalr = 4'd7,
        OpSw   = 4'd8,
        OpLw   = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StErr  = 2'd2
    } state_e;

    // RV32I major opcodes
    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLui   = 7'b0110111;
    localparam logic [6:0] OpcJal   = 7'b1101111;
    localparam logic [6:0] OpcJalr  = 7'b1100111;
    localparam logic [6:0] OpcStore = 7'b0100011;
    localparam logic [6:0] OpcLoad  = 7'b0000011;

    // funct3 / funct7
    localparam logic [2:0] F3AddSub = 3'b000;
    localparam logic [2:0] F3And    = 3'b111;
    localparam logic [2:0] F3Or     = 3'b110;
    localparam logic [2:0] F3Word   = 3'b010;
    localparam logic [2:0] F3Jalr   = 3'b000;
    localparam logic [6:0] F7Base   = 7'b0000000;
    localparam logic [6:0] F7Sub    = 7'b0100000;

    localparam logic [31:0] Nop = 32'h0000_0013;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OpcOp};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                          logic [4:0] rd, logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                          logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], OpcStore};
    endfunction

    // j holds imm[20:1]; scattered into the J-type layout.
    function automatic logic [31:0] enc_j(logic [19:0] j, logic [4:0] rd);
        return {j[19], j[9:0], j[10], j[18:11], rd, OpcJal};
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Micro-op input channel and instruction-memory write channel.
// master: drives micro-ops and mem_ready (producer / memory side).
// slave : the encoder (accepts micro-ops, issues writes).
interface inst_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I field packer and immediate range checker.
// Ports: op/rd/rs1/rs2/imm micro-op fields in; word = encoded instruction,
// ok = op is defined and its immediate is encodable.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        ok
);
    logic imm12_fits;
    logic jal_fits;
    logic lui_fits;

    // Sign-extension check: all bits above the field's sign bit match it.
    assign imm12_fits = (&imm[31:11]) || !(|imm[31:11]);
    assign jal_fits   = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
    assign lui_fits   = !(|imm[11:0]);

    always_comb begin
        word = Nop;
        ok   = 1'b0;
        unique case (op_e'(op))
            OpAdd: begin word = enc_r(F7Base, rs2, rs1, F3AddSub, rd); ok = 1'b1; end
            OpSub: begin word = enc_r(F7Sub,  rs2, rs1, F3AddSub, rd); ok = 1'b1; end
            OpAnd: begin word = enc_r(F7Base, rs2, rs1, F3And,    rd); ok = 1'b1; end
            OpOr:  begin word = enc_r(F7Base, rs2, rs1, F3Or,     rd); ok = 1'b1; end
            OpAddi: begin
                word = enc_i(imm[11:0], rs1, F3AddSub, rd, OpcOpImm);
                ok   = imm12_fits;
            end
            OpLui: begin
                word = {imm[31:12], rd, OpcLui};
                ok   = lui_fits;
            end
            OpJal: begin
                word = enc_j(imm[20:1], rd);
                ok   = jal_fits;
            end
            OpJalr: begin
                word = enc_i(imm[11:0], rs1, F3Jalr, rd, OpcJalr);
                ok   = imm12_fits;
            end
            OpSw: begin
                word = enc_s(imm[11:0], rs2, rs1, F3Word);
                ok   = imm12_fits;
            end
            OpLw: begin
                word = enc_i(imm[11:0], rs1, F3Word, rd, OpcLoad);
                ok   = imm12_fits;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/inst_encoder.sv
// Micro-op to RV32I instruction encoder writing sequential words to memory.
// Ports: clk, rst_n (sync, active-low), start/base_addr (begin a run),
// bus (micro-op in, memory write out), count (words written), err (sticky).
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    inst_encoder_if.slave     bus,
    output logic [ADDR_W-3:0] count,
    output logic              err
);
    state_e            state_q, state_d;
    logic              mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-3:0] widx_q, widx_d;   // next write word index
    logic [ADDR_W-3:0] count_q, count_d;
    logic              err_q, err_d;
    logic              in_ready;
    logic              accept;
    logic [31:0]       pack_word;
    logic              pack_ok;
    logic              unused_base;

    assign unused_base = ^base_addr[1:0];

    inst_pack u_pack (
        .op   (bus.in_op),
        .rd   (bus.in_rd),
        .rs1  (bus.in_rs1),
        .rs2  (bus.in_rs2),
        .imm  (bus.in_imm),
        .word (pack_word),
        .ok   (pack_ok)
    );

    assign in_ready = (state_q == StRun) && (!mem_valid_q || bus.mem_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        widx_d      = widx_q;
        count_d     = count_q;
        err_d       = err_q;

        if (mem_valid_q && bus.mem_ready) begin
            mem_valid_d = 1'b0;
        end

        if (start) begin
            // Restart discards any undrained entry.
            state_d     = StRun;
            mem_valid_d = 1'b0;
            widx_d      = base_addr[ADDR_W-1:2];
            count_d     = '0;
            err_d       = 1'b0;
        end else if (accept) begin
            if (pack_ok) begin
                // Reload in the same cycle as a drain keeps full throughput.
                mem_valid_d = 1'b1;
                mem_addr_d  = {widx_q, 2'b00};
                mem_wdata_d = pack_word;
                widx_d      = widx_q + 1'b1;
                count_d     = count_q + 1'b1;
            end else begin
                state_d = StErr;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            widx_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            widx_q      <= widx_d;
            count_q     <= count_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign count         = count_q;
    assign err           = err_q;
endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    import inst_encoder_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic [9:0] base_a;
    logic [3:0] base_b;
    logic [7:0] count_a;
    logic [1:0] count_b;
    logic       err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    inst_encoder_if #(.ADDR_W(10)) bus_a ();
    inst_encoder_if #(.ADDR_W(4))  bus_b ();

    inst_encoder #(.ADDR_W(10)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_a),
        .base_addr (base_a),
        .bus       (bus_a),
        .count     (count_a),
        .err       (err_a)
    );

    inst_encoder #(.ADDR_W(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_b),
        .base_addr (base_b),
        .bus       (bus_b),
        .count     (count_b),
        .err       (err_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input op_e op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] imm);
        bus_a.in_valid = v;
        bus_a.in_op    = op;
        bus_a.in_rd    = rd;
        bus_a.in_rs1   = rs1;
        bus_a.in_rs2   = rs2;
        bus_a.in_imm   = imm;
    endtask

    task automatic start_run_a(input logic [9:0] base);
        start_a = 1'b1;
        base_a  = base;
        tick();
        start_a = 1'b0;
    endtask

    // One accepted op (mem_ready=1), then check the write it produced.
    task automatic send_a(input string tag, input op_e op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                          input logic [31:0] exp_word, input logic [9:0] exp_addr);
        drive_a(1'b1, op, rd, rs1, rs2, imm);
        tick();
        bus_a.in_valid = 1'b0;
        check({tag, " valid"}, {31'd0, bus_a.mem_valid}, 32'd1);
        check({tag, " wdata"}, bus_a.mem_wdata, exp_word);
        check({tag, " addr"}, {22'd0, bus_a.mem_addr}, {22'd0, exp_addr});
    endtask

    logic [3:0] exp_addr_b [4];
    logic [1:0] exp_cnt_b  [4];

    initial begin
        exp_addr_b = '{4'hC, 4'h0, 4'h4, 4'h8};
        exp_cnt_b  = '{2'd1, 2'd2, 2'd3, 2'd0};

        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        base_a  = '0;
        base_b  = '0;
        drive_a(1'b0, OpAdd, 5'd0, 5'd0, 5'd0, 32'd0);
        bus_a.mem_ready = 1'b1;
        bus_b.in_valid  = 1'b0;
        bus_b.in_op     = OpAdd;
        bus_b.in_rd     = 5'd3;
        bus_b.in_rs1    = 5'd1;
        bus_b.in_rs2    = 5'd2;
        bus_b.in_imm    = 32'd0;
        bus_b.mem_ready = 1'b1;
        tick();
        tick();

        check("rst valid", {31'd0, bus_a.mem_valid}, 32'd0);
        check("rst addr", {22'd0, bus_a.mem_addr}, 32'd0);
        check("rst wdata", bus_a.mem_wdata, 32'd0);
        check("rst count", {24'd0, count_a}, 32'd0);
        check("rst err", {31'd0, err_a}, 32'd0);
        check("rst in_ready", {31'd0, bus_a.in_ready}, 32'd0);

        rst_n = 1'b1;
        tick();
        check("idle in_ready", {31'd0, bus_a.in_ready}, 32'd0);

        // Narrow instance: address and count wrap.
        start_b = 1'b1;
        base_b  = 4'hC;
        tick();
        start_b = 1'b0;
        bus_b.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("wrap addr %0d", i), {28'd0, bus_b.mem_addr}, {28'd0, exp_addr_b[i]});
            check($sformatf("wrap count %0d", i), {30'd0, count_b}, {30'd0, exp_cnt_b[i]});
        end
        bus_b.in_valid = 1'b0;

        // Basic encodings.
        start_run_a(10'h040);
        check("run in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        send_a("add", OpAdd, 5'd3, 5'd1, 5'd2, 32'd0, 32'h0020_81B3, 10'h040);
        send_a("sub", OpSub, 5'd3, 5'd1, 5'd2, 32'd0, 32'h4020_81B3, 10'h044);
        check("count 2", {24'd0, count_a}, 32'd2);
        send_a("addi", OpAddi, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093, 10'h048);
        send_a("lui", OpLui, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7, 10'h04C);
        send_a("sw", OpSw, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_A423, 10'h050);
        send_a("jal", OpJal, 5'd1, 5'd0, 5'd0, 32'd8, 32'h0080_00EF, 10'h054);
        check("count 6", {24'd0, count_a}, 32'd6);
        tick();
        check("drained", {31'd0, bus_a.mem_valid}, 32'd0);

        // Backpressure: entry held while mem_ready is low.
        bus_a.mem_ready = 1'b0;
        drive_a(1'b1, OpAddi, 5'd2, 5'd0, 5'd0, 32'd7);
        tick();
        drive_a(1'b1, OpAdd, 5'd3, 5'd1, 5'd2, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold in_ready %0d", i), {31'd0, bus_a.in_ready}, 32'd0);
            check($sformatf("hold valid %0d", i), {31'd0, bus_a.mem_valid}, 32'd1);
            check($sformatf("hold wdata %0d", i), bus_a.mem_wdata, 32'h0070_0113);
            check($sformatf("hold addr %0d", i), {22'd0, bus_a.mem_addr}, 32'h058);
            tick();
        end
        check("hold count", {24'd0, count_a}, 32'd7);

        // Stream: one word per cycle once mem_ready returns.
        bus_a.mem_ready = 1'b1;
        tick();
        check("stream add", bus_a.mem_wdata, 32'h0020_81B3);
        check("stream add addr", {22'd0, bus_a.mem_addr}, 32'h05C);
        drive_a(1'b1, OpSub, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        check("stream sub", bus_a.mem_wdata, 32'h4020_81B3);
        check("stream sub addr", {22'd0, bus_a.mem_addr}, 32'h060);
        drive_a(1'b1, OpAnd, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        check("stream and", bus_a.mem_wdata, 32'h0020_F1B3);
        check("stream and addr", {22'd0, bus_a.mem_addr}, 32'h064);
        drive_a(1'b1, OpOr, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        check("stream or", bus_a.mem_wdata, 32'h0020_E1B3);
        check("stream or addr", {22'd0, bus_a.mem_addr}, 32'h068);
        bus_a.in_valid = 1'b0;
        tick();
        check("stream end valid", {31'd0, bus_a.mem_valid}, 32'd0);
        check("stream count", {24'd0, count_a}, 32'd11);

        // Reject: immediate just out of range.
        drive_a(1'b1, OpAddi, 5'd1, 5'd0, 5'd0, 32'd2048);
        tick();
        bus_a.in_valid = 1'b0;
        check("rej err", {31'd0, err_a}, 32'd1);
        check("rej in_ready", {31'd0, bus_a.in_ready}, 32'd0);
        check("rej valid", {31'd0, bus_a.mem_valid}, 32'd0);
        check("rej count", {24'd0, count_a}, 32'd11);

        start_run_a(10'h103);
        check("restart err", {31'd0, err_a}, 32'd0);
        check("restart count", {24'd0, count_a}, 32'd0);
        check("restart in_ready", {31'd0, bus_a.in_ready}, 32'd1);
        send_a("addi min", OpAddi, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 32'h8000_0093, 10'h100);
        drive_a(1'b1, op_e'(4'hF), 5'd1, 5'd1, 5'd1, 32'd0);
        tick();
        bus_a.in_valid = 1'b0;
        check("undef err", {31'd0, err_a}, 32'd1);
        check("undef count", {24'd0, count_a}, 32'd1);

        // Reset while a write is stalled.
        start_run_a(10'h000);
        bus_a.mem_ready = 1'b0;
        drive_a(1'b1, OpAdd, 5'd3, 5'd1, 5'd2, 32'd0);
        tick();
        bus_a.in_valid = 1'b0;
        check("pre-rst valid", {31'd0, bus_a.mem_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("midrst valid", {31'd0, bus_a.mem_valid}, 32'd0);
        check("midrst wdata", bus_a.mem_wdata, 32'd0);
        check("midrst addr", {22'd0, bus_a.mem_addr}, 32'd0);
        check("midrst count", {24'd0, count_a}, 32'd0);
        rst_n = 1'b1;
        bus_a.mem_ready = 1'b1;
        tick();
        check("midrst idle", {31'd0, bus_a.in_ready}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
